// File: rtl/bus_dma_master.sv
// Single-channel word copy engine: acquires the shared bus, reads each source
// word into a holding register, then writes it to the destination.
module bus_dma_master #(
  parameter int LEN_W  = 8,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  words_done,
  output logic              m_req,
  input  logic              m_grant,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dout,
  input  logic [DATA_W-1:0] m_din,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_GNT = 3'd1,
    S_RD_ADDR  = 3'd2,
    S_RD_DATA  = 3'd3,
    S_WR       = 3'd4,
    S_FIN      = 3'd5
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_dst;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_data;
  logic                r_abort_exit;
  logic                r_busy;
  logic                r_done;
  logic                r_aborted;
  logic                r_m_req;
  logic                r_m_wr;
  logic [ADDR_W-1:0]   r_m_addr;

  logic [LEN_W-1:0]    w_cnt_inc;
  logic                w_last;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_last    = (w_cnt_inc == r_len);

  // Bus handshake: m_req is held for the whole copy; a bus cycle only takes
  // effect if m_grant is sampled high at its closing edge, otherwise the FSM
  // falls back to WAIT_GNT and replays the current word from its read.
  // Read data on m_din is valid the cycle after the read address is driven.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_data       <= '0;
      r_abort_exit <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_m_req      <= 1'b0;
      r_m_wr       <= 1'b0;
      r_m_addr     <= '0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_busy       <= 1'b1;
            r_cnt        <= '0;
            r_abort_exit <= 1'b0;
            if (length != '0) begin
              r_src   <= src_addr;
              r_dst   <= dst_addr;
              r_len   <= length;
              r_m_req <= 1'b1;
              r_m_wr  <= 1'b0;
              r_state <= S_WAIT_GNT;
            end else begin
              r_state <= S_FIN;
            end
          end
        end
        S_FIN: begin
          r_m_req   <= 1'b0;
          r_m_wr    <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= !r_abort_exit;
          r_aborted <= r_abort_exit;
          r_state   <= S_IDLE;
        end
        default: begin
          if (abort) begin
            r_m_req      <= 1'b0;
            r_m_wr       <= 1'b0;
            r_abort_exit <= 1'b1;
            r_state      <= S_FIN;
          end else begin
            case (r_state)
              S_WAIT_GNT: begin
                if (m_grant) begin
                  r_m_addr <= r_src;
                  r_state  <= S_RD_ADDR;
                end
              end
              S_RD_ADDR: begin
                r_state <= m_grant ? S_RD_DATA : S_WAIT_GNT;
              end
              S_RD_DATA: begin
                if (!m_grant) begin
                  r_state <= S_WAIT_GNT;
                end else begin
                  r_data   <= m_din;
                  r_m_addr <= r_dst;
                  r_m_wr   <= 1'b1;
                  r_state  <= S_WR;
                end
              end
              S_WR: begin
                r_m_wr <= 1'b0;
                if (!m_grant) begin
                  r_state <= S_WAIT_GNT;
                end else begin
                  r_cnt <= w_cnt_inc;
                  r_src <= r_src + 1'b1;
                  r_dst <= r_dst + 1'b1;
                  if (w_last) begin
                    r_m_req <= 1'b0;
                    r_state <= S_FIN;
                  end else begin
                    r_m_addr <= r_src + 1'b1;
                    r_state  <= S_RD_ADDR;
                  end
                end
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign aborted    = r_aborted;
  assign words_done = r_cnt;
  assign m_req      = r_m_req;
  assign m_wr       = r_m_wr;
  assign m_addr     = r_m_addr;
  assign m_dout     = r_data;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_bus_dma_master.sv
// Bench for bus_dma_master: bus slave memory and arbiter models, directed and
// random copies, write scoreboard fed by a sequential copy reference model.
module tb_bus_dma_master;

  localparam logic [2:0] ST_RD_DATA = 3'd3;
  localparam logic [2:0] ST_WR      = 3'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        drv_abort;
  logic        inj_abort;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [7:0]  length;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [7:0]  words_done;
  logic        m_req;
  logic        m_grant;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [31:0] m_dout;
  logic [31:0] m_din;
  logic [2:0]  dbg_state;

  logic [31:0] mem [0:65535];
  logic [47:0] exp_q [$];

  int n_checks = 0;
  int n_errors = 0;
  int write_cnt, done_cnt, abort_cnt, gcyc_cnt, req_cnt;
  int gnt_delay = 0;
  int drop_pct = 0;
  bit drop_arm = 0;
  bit abort_arm = 0;

  assign abort = drv_abort | inj_abort;

  bus_dma_master #(.LEN_W(8), .ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done), .aborted(aborted), .words_done(words_done),
    .m_req(m_req), .m_grant(m_grant), .m_wr(m_wr), .m_addr(m_addr),
    .m_dout(m_dout), .m_din(m_din), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus slave: registered read select (data one cycle after address), writes on granted m_wr.
  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = $urandom;
    m_din = '0;
    forever begin
      @(posedge clk);
      m_din <= mem[m_addr];
      if (m_wr && m_grant) mem[m_addr] = m_dout;
    end
  end

  // Arbiter plus targeted grant-drop and abort injection, updated just after each edge.
  initial begin
    int wcnt;
    m_grant = 1'b0;
    inj_abort = 1'b0;
    wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!m_req) begin
        m_grant = 1'b0;
        wcnt = 0;
      end else if (!m_grant) begin
        if (wcnt >= gnt_delay) m_grant = 1'b1;
        else wcnt++;
      end else if ((drop_arm && dbg_state == ST_RD_DATA && words_done == 8'd1) ||
                   ($urandom_range(0, 99) < drop_pct)) begin
        m_grant = 1'b0;
        wcnt = 0;
        drop_arm = 0;
      end
      inj_abort = 1'b0;
      if (abort_arm && dbg_state == ST_WR && words_done == 8'd2 && m_grant) begin
        inj_abort = 1'b1;
        abort_arm = 0;
      end
    end
  end

  // Monitor: scores every granted write against the expected queue.
  initial begin
    bit prev_g, prev_abort, chk_req_next;
    logic [47:0] e;
    prev_g = 0; prev_abort = 0; chk_req_next = 0;
    forever begin
      @(negedge clk);
      if (chk_req_next) begin
        check("m_req low after last write", m_req, 0);
        chk_req_next = 0;
      end
      if (prev_abort) check("m_req low after abort", m_req, 0);
      if (m_req) req_cnt++;
      if (m_req && m_grant && prev_g) gcyc_cnt++;
      if (m_wr && m_grant) begin
        write_cnt++;
        if (exp_q.size() == 0) begin
          check("write with nothing expected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("write addr", m_addr, e[47:32]);
          check("write data", m_dout, e[31:0]);
          if (exp_q.size() == 0) chk_req_next = 1;
        end
      end
      if (done) done_cnt++;
      if (aborted) abort_cnt++;
      prev_g = m_grant;
      prev_abort = abort && busy && !reset;
    end
  end

  // Reference model: words copied one at a time in order, so later reads see earlier writes.
  task automatic push_expected(input logic [15:0] s, input logic [15:0] d, input int n);
    logic [31:0] shadow [logic [15:0]];
    logic [15:0] sa, da;
    logic [31:0] v;
    for (int i = 0; i < n; i++) begin
      sa = s + 16'(i);
      da = d + 16'(i);
      v = shadow.exists(sa) ? shadow[sa] : mem[sa];
      shadow[da] = v;
      exp_q.push_back({da, v});
    end
  endtask

  task automatic clear_counts();
    write_cnt = 0; done_cnt = 0; abort_cnt = 0; gcyc_cnt = 0; req_cnt = 0;
  endtask

  task automatic pulse_start(input logic [15:0] s, input logic [15:0] d, input int len);
    @(posedge clk); #1;
    start = 1'b1; src_addr = s; dst_addr = d; length = 8'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    bit seen;
    seen = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (done || aborted) seen = 1;
    end
    check({tag, " completion within bound"}, seen, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input int len,
                          input int gd, input int dp, input bit drop2, input bit abrt,
                          input string tag);
    int nexp;
    nexp = abrt ? 3 : len;
    push_expected(s, d, nexp);
    clear_counts();
    gnt_delay = gd; drop_pct = dp; drop_arm = drop2; abort_arm = abrt;
    pulse_start(s, d, len);
    wait_end(tag);
    check({tag, " done pulses"}, done_cnt, abrt ? 0 : 1);
    check({tag, " aborted pulses"}, abort_cnt, abrt ? 1 : 0);
    check({tag, " words_done"}, words_done, abrt ? 2 : len);
    check({tag, " bus writes"}, write_cnt, nexp);
    check({tag, " writes left"}, exp_q.size(), 0);
    check({tag, " busy after end"}, busy, 0);
    drop_pct = 0; drop_arm = 0; abort_arm = 0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; drv_abort = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset aborted", aborted, 0);
    check("reset words_done", words_done, 0);
    check("reset m_req", m_req, 0);
    check("reset m_wr", m_wr, 0);
    check("reset m_addr", m_addr, 0);
    check("reset m_dout", m_dout, 0);

    run_copy(16'h0100, 16'h0200, 4, 2, 0, 0, 0, "copy4");
    check("copy4 granted bus cycles", gcyc_cnt, 12);

    clear_counts();
    pulse_start(16'h1234, 16'h5678, 0);
    @(negedge clk);
    check("len0 done one cycle after start", done, 0);
    @(negedge clk);
    check("len0 done two cycles after start", done, 1);
    repeat (3) @(negedge clk);
    check("len0 m_req cycles", req_cnt, 0);
    check("len0 words_done", words_done, 0);
    check("len0 done pulses", done_cnt, 1);

    run_copy(16'h0300, 16'h0400, 3, 1, 0, 1, 0, "gntdrop");
    for (int i = 0; i < 3; i++)
      check("gntdrop dst equals src", mem[16'h0400 + i], mem[16'h0300 + i]);

    run_copy(16'h0500, 16'h0600, 5, 0, 0, 0, 1, "abort");
    run_copy(16'hFFFE, 16'h0010, 3, 1, 0, 0, 0, "wrap");

    clear_counts();
    @(posedge clk); #1;
    start = 1'b1; drv_abort = 1'b1; length = 8'd5;
    @(posedge clk); #1;
    start = 1'b0; drv_abort = 1'b0;
    @(negedge clk);
    check("start+abort idle busy", busy, 0);
    repeat (3) @(negedge clk);
    check("start+abort idle m_req cycles", req_cnt, 0);

    for (int t = 0; t < 8; t++)
      run_copy(16'($urandom), 16'($urandom), $urandom_range(1, 10), $urandom_range(0, 3),
               ($urandom_range(0, 1) == 1) ? 20 : 0, 0, 0, "random");

    push_expected(16'h0800, 16'h0900, 6);
    clear_counts();
    gnt_delay = 1;
    pulse_start(16'h0800, 16'h0900, 6);
    for (int c = 0; c < 500 && write_cnt < 2; c++) @(negedge clk);
    check("midreset reached two writes", write_cnt >= 2, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midreset busy", busy, 0);
    check("midreset words_done", words_done, 0);
    check("midreset m_req", m_req, 0);
    check("midreset m_wr", m_wr, 0);
    check("midreset m_addr", m_addr, 0);
    check("midreset m_dout", m_dout, 0);
    exp_q.delete();
    repeat (4) @(negedge clk);
    check("midreset no done", done_cnt, 0);
    check("midreset no aborted", abort_cnt, 0);

    push_expected(16'h0A00, 16'h0B00, 4);
    clear_counts();
    pulse_start(16'h0A00, 16'h0B00, 4);
    repeat (3) @(posedge clk);
    #1 start = 1'b1; src_addr = 16'h0C00; dst_addr = 16'h0D00; length = 8'd7;
    @(posedge clk); #1 start = 1'b0;
    wait_end("busystart");
    check("busystart words_done", words_done, 4);
    check("busystart bus writes", write_cnt, 4);
    check("busystart done pulses", done_cnt, 1);
    check("busystart writes left", exp_q.size(), 0);

    run_copy(16'h0C00, 16'h0D00, 7, 2, 0, 0, 0, "postreset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got no end expected end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bus_dma_master.md
Name: bus_dma_master

Overview:
- Single-channel memory-to-memory copy engine acting as a bus master (connects to either master port, m0_* or m1_*, of the shared bus).
- On start it acquires the bus through the arbiter and copies `length` 32-bit words from src_addr to dst_addr.
- Each word is read from a slave, held internally, then written to a slave.
- Reports busy/done/aborted status and progress to its controller.

Parameters:
- LEN_W, 8, width of length and word counter (max copy = 2^LEN_W - 1 words)
- ADDR_W, 16, bus address width
- DATA_W, 32, bus data width

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; latches src_addr/dst_addr/length when IDLE
- abort  input  1  terminate the current copy
- src_addr  input  ADDR_W  first source word address
- dst_addr  input  ADDR_W  first destination word address
- length  input  LEN_W  number of words to copy
- busy  output  1  high from the cycle after an accepted start until return to IDLE
- done  output  1  one-cycle pulse on normal completion
- aborted  output  1  one-cycle pulse on abort completion
- words_done  output  LEN_W  words written so far in the current or last copy
- m_req  output  1  bus request to the arbiter
- m_grant  input  1  bus grant from the arbiter
- m_wr  output  1  1 = write, 0 = read
- m_addr  output  ADDR_W  bus address
- m_dout  output  DATA_W  write data to the bus
- m_din  input  DATA_W  read data from the bus; valid the cycle after a read address is presented

Behaviour:
- Reset: state IDLE; m_req=0, m_wr=0, m_addr=0, m_dout=0, busy=0, done=0, aborted=0, words_done=0; internal src/dst/count/data registers cleared.
- States:
  - IDLE
  - WAIT_GNT
  - RD_ADDR
  - RD_DATA
  - WR
  - FIN
- IDLE:
  - start=1 and length!=0: latch the inputs, clear words_done, go to WAIT_GNT.
  - start=1 and length==0: go to FIN with no bus request, so done pulses two cycles after start.
  - start while not IDLE is ignored.
- WAIT_GNT: m_req=1, m_wr=0. When m_grant=1 (sampled), go to RD_ADDR.
- RD_ADDR: m_addr=cur_src, m_wr=0. Go to RD_DATA.
- RD_DATA:
  - m_addr is held at cur_src, m_wr=0.
  - At the end of the cycle, m_din is captured into the data register; this gives 1-cycle read latency through the bus's registered read-select.
  - Go to WR.
- WR:
  - m_addr=cur_dst, m_wr=1, m_dout=data register.
  - At the end of the cycle: words_done+1, cur_src+1, cur_dst+1.
  - If words_done+1 == length, go to FIN; else go to RD_ADDR. m_req stays high between words, so there is no re-arbitration.
- FIN:
  - m_req=0, m_wr=0.
  - Pulse done, or aborted if the exit was an abort.
  - Go to IDLE.
- Throughput: 3 cycles per word once granted.
- m_req stays high from WAIT_GNT through the last WR cycle. m_wr is high only in WR.
- Outputs m_req, m_wr, m_addr and m_dout are registered (driven from state/registers, not from inputs combinationally).
- Grant loss: if m_grant=0 in RD_ADDR, RD_DATA or WR:
  - The cycle has no effect: no capture, no counter/address update, m_wr forced 0.
  - Go to WAIT_GNT, keeping m_req=1.
  - The current word restarts from RD_ADDR after re-grant, so no word is skipped or duplicated-written with stale data.
- Address wrap: cur_src/cur_dst increment modulo 2^ADDR_W (0xFFFF -> 0x0000).
- Abort:
  - In any non-IDLE state except FIN, abort=1 drops m_req and forces m_wr=0 on the next cycle, then enters FIN with aborted pulse and no done.
  - words_done keeps the count of completed writes; a WR cycle coincident with abort does not count.
  - Abort in IDLE is ignored.
- Simultaneous start and abort in IDLE: abort has priority; nothing starts.
- reset=1 at any time (mid-copy included) returns to the reset state on the next edge; no done/aborted pulse is produced.

Test Plan:
- Copy 4 words, src=0x0100, dst=0x0200, grant 2 cycles after req:
  - Writes occur in order to 0x0200..0x0203 with the data read from 0x0100..0x0103.
  - done pulses once; words_done=4.
  - 12 granted bus cycles total; m_req low after the last WR.
- length=0: done pulses two cycles after start; m_req never asserted; words_done=0.
- Grant withdrawn during the RD_DATA of word 2 of a 3-word copy:
  - DMA returns to WAIT_GNT and re-reads the word-2 source after re-grant.
  - Destination contents equal the source; exactly 3 write cycles.
- Abort asserted in WR of word 3 of a 5-word copy:
  - That write is not counted.
  - aborted pulses; done never pulses; words_done=2; m_req=0 by the next cycle.
- src=0xFFFE, dst=0x0010, length=3: reads 0xFFFE, 0xFFFF, 0x0000; writes 0x0010..0x0012.
- reset pulsed mid-copy, then start asserted while busy:
  - The mid-copy reset clears all outputs to zero.
  - A start issued during busy is ignored (copy parameters unchanged); a new start after IDLE copies correctly.
